// File: rtl/phase_ramp_if.sv
// ---------------------------------------------------------------------------
// phase_ramp_if
// Groups the sample stream, phase-control inputs and phase-tagged output of
// phase_ramp_gen. Clock and reset remain plain module ports.
//
//   enable        : pipeline advance (low = everything holds)
//   freq_offset   : signed per-sample phase increment (PI_VAL scaling)
//   freq_valid    : load freq_offset as the new increment
//   sync          : packet start, restarts the phase ramp
//   freeze        : hold the accumulator while samples keep flowing
//   in_i/in_q     : input sample, qualified by input_strobe
//   out_i/out_q   : delayed sample, qualified by output_strobe
//   phase         : signed phase attached to that output sample
//   sample_count  : samples accepted since the last sync (saturating)
//
// CNT_WIDTH must match the CNT_WIDTH of the phase_ramp_gen it is bound to.
// ---------------------------------------------------------------------------
interface phase_ramp_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic signed [15:0]   freq_offset;
    logic                 freq_valid;
    logic                 sync;
    logic                 freeze;
    logic [15:0]          in_i;
    logic [15:0]          in_q;
    logic                 input_strobe;
    logic [15:0]          out_i;
    logic [15:0]          out_q;
    logic signed [31:0]   phase;
    logic                 output_strobe;
    logic [CNT_WIDTH-1:0] sample_count;

    // Driver side (sample source / controller).
    modport master (
        output enable, freq_offset, freq_valid, sync, freeze,
        output in_i, in_q, input_strobe,
        input  out_i, out_q, phase, output_strobe, sample_count
    );

    // Phase ramp generator side.
    modport slave (
        input  enable, freq_offset, freq_valid, sync, freeze,
        input  in_i, in_q, input_strobe,
        output out_i, out_q, phase, output_strobe, sample_count
    );
endinterface

// File: rtl/phase_ramp_gen.sv
// ---------------------------------------------------------------------------
// phase_ramp_gen
// Attaches a linearly advancing phase to every sample of a packet. A signed
// increment (saturated to +/-PI_VAL) is added to an 18-bit accumulator once
// per accepted sample; the accumulator wraps into [-PI_VAL, PI_VAL]. Samples
// leave two enabled cycles after they arrive, paired with the phase they were
// given on entry.
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active low (0 = reset)
//   bus   : phase_ramp_if.slave (controls, input sample, output sample,
//           phase, output_strobe, sample_count)
// ---------------------------------------------------------------------------
module phase_ramp_gen #(
    parameter int PI_VAL    = 1608,
    parameter int CNT_WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    phase_ramp_if.slave   bus
);
    localparam int AW    = 18;  // accumulator width
    localparam int DEPTH = 2;   // input-to-output latency in enabled cycles

    localparam logic signed [AW-1:0] PI_A     = AW'(PI_VAL);
    localparam logic signed [AW:0]   PI_W     = (AW + 1)'(PI_VAL);
    localparam logic signed [AW:0]   TWO_PI_W = (AW + 1)'(2 * PI_VAL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [AW-1:0]   inc_q, inc_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic                   accept;
    logic                   accumulate;
    logic signed [AW-1:0]   freq_ext;
    logic signed [AW-1:0]   freq_sat;
    logic signed [AW-1:0]   acc_base;
    logic signed [AW-1:0]   inc_step;
    logic signed [AW:0]     sum;
    logic signed [AW:0]     wrapped;

    // -----------------------------------------------------------------
    // Phase datapath
    // -----------------------------------------------------------------
    always_comb begin
        accept   = bus.enable && bus.input_strobe;
        freq_ext = {{(AW - 16){bus.freq_offset[15]}}, bus.freq_offset};

        if (freq_ext > PI_A) begin
            freq_sat = PI_A;
        end else if (freq_ext < -PI_A) begin
            freq_sat = -PI_A;
        end else begin
            freq_sat = freq_ext;
        end

        // sync restarts the ramp in the same cycle, so a sample arriving
        // with sync sees phase 0 and the step builds on zero.
        acc_base = bus.sync ? '0 : acc_q;

        // A fresh increment only takes part in this cycle's step when it
        // arrives together with sync; otherwise it applies from the next step.
        inc_step = (bus.sync && bus.freq_valid) ? freq_sat : inc_q;

        // One extra bit holds the raw sum (|sum| <= 2*PI_VAL) before wrapping.
        sum = {acc_base[AW-1], acc_base} + {inc_step[AW-1], inc_step};
        if (sum > PI_W) begin
            wrapped = sum - TWO_PI_W;
        end else if (sum < -PI_W) begin
            wrapped = sum + TWO_PI_W;
        end else begin
            wrapped = sum;
        end

        // freeze acts on the sample presented with it, so the update is
        // gated by the live input rather than by the registered HOLD state.
        accumulate = accept && (state_q != IDLE || bus.freq_valid) && !bus.freeze;
    end

    // -----------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        inc_d   = inc_q;
        count_d = count_q;

        if (bus.enable) begin
            unique case (state_q)
                IDLE:    if (bus.freq_valid) state_d = RUN;
                RUN:     if (bus.freeze)     state_d = HOLD;
                HOLD:    if (!bus.freeze)    state_d = RUN;
                default:                     state_d = IDLE;
            endcase

            if (bus.freq_valid) begin
                inc_d = freq_sat;
            end

            if (bus.sync) begin
                acc_d   = '0;
                count_d = '0;
            end

            if (accept) begin
                if (bus.sync) begin
                    count_d = CNT_WIDTH'(1);
                end else if (count_q != {CNT_WIDTH{1'b1}}) begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end

            if (accumulate) begin
                acc_d = wrapped[AW-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            inc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------
    // Sample pipeline. Stage 0 captures the sample with its phase; the last
    // stage drives the outputs. The last stage's strobe drops whenever
    // enable is low so a held sample is never presented twice.
    // -----------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic                 vld_q, vld_d, vld_in;
            logic [15:0]          i_q, i_d, i_in;
            logic [15:0]          q_q, q_d, q_in;
            logic signed [AW-1:0] ph_q, ph_d, ph_in;

            if (gi == 0) begin : g_src
                assign vld_in = bus.input_strobe;
                assign i_in   = bus.in_i;
                assign q_in   = bus.in_q;
                assign ph_in  = acc_base;  // zero in IDLE since acc stays 0
            end else begin : g_src
                assign vld_in = g_stage[gi-1].vld_q;
                assign i_in   = g_stage[gi-1].i_q;
                assign q_in   = g_stage[gi-1].q_q;
                assign ph_in  = g_stage[gi-1].ph_q;
            end

            always_comb begin
                vld_d = (gi == DEPTH - 1) ? 1'b0 : vld_q;
                i_d   = i_q;
                q_d   = q_q;
                ph_d  = ph_q;
                if (bus.enable) begin
                    vld_d = vld_in;
                    i_d   = i_in;
                    q_d   = q_in;
                    ph_d  = ph_in;
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    vld_q <= 1'b0;
                    i_q   <= '0;
                    q_q   <= '0;
                    ph_q  <= '0;
                end else begin
                    vld_q <= vld_d;
                    i_q   <= i_d;
                    q_q   <= q_d;
                    ph_q  <= ph_d;
                end
            end
        end
    endgenerate

    assign bus.output_strobe = g_stage[DEPTH-1].vld_q;
    assign bus.out_i         = g_stage[DEPTH-1].i_q;
    assign bus.out_q         = g_stage[DEPTH-1].q_q;
    assign bus.phase         = {{(32 - AW){g_stage[DEPTH-1].ph_q[AW-1]}}, g_stage[DEPTH-1].ph_q};
    assign bus.sample_count  = count_q;

endmodule

// File: tb/tb_phase_ramp_gen.sv
// ---------------------------------------------------------------------------
// tb_phase_ramp_gen
// Scoreboard bench for phase_ramp_gen. A reference process evaluates the
// phase-ramp rules with plain integer arithmetic at every clock edge and
// queues the expected output sample; an independent monitor pops and compares
// whenever output_strobe is seen. A narrow counter (CW=4) makes sample_count
// saturation reachable.
// ---------------------------------------------------------------------------
module tb_phase_ramp_gen;
    localparam int PI = 1608;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phase_ramp_if #(.CNT_WIDTH(CW)) bus ();

    phase_ramp_gen #(.PI_VAL(PI), .CNT_WIDTH(CW)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int i;
        int q;
        int ph;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state
    int   m_acc    = 0;
    int   m_inc    = 0;
    int   m_cnt    = 0;
    bit   m_loaded = 1'b0;
    int   en_cnt   = 0;
    int   m_f;
    exp_t m_e;
    exp_t mon_e;

    function automatic int wrapf(input int s);
        if (s > PI)  return s - 2 * PI;
        if (s < -PI) return s + 2 * PI;
        return s;
    endfunction

    function automatic int satf(input int f);
        if (f > PI)  return PI;
        if (f < -PI) return -PI;
        return f;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, req, $time);
        end
    endtask

    // Reference model: evaluated on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_acc    = 0;
            m_inc    = 0;
            m_cnt    = 0;
            m_loaded = 1'b0;
            sb.delete();
        end else if (bus.enable) begin
            en_cnt++;
            m_f = satf(int'(bus.freq_offset));
            if (bus.input_strobe) begin
                m_e.i   = int'(bus.in_i);
                m_e.q   = int'(bus.in_q);
                m_e.ph  = bus.sync ? 0 : m_acc;
                m_e.tag = en_cnt;
                sb.push_back(m_e);
                if (bus.sync)                 m_cnt = 1;
                else if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                if ((m_loaded || bus.freq_valid) && !bus.freeze)
                    m_acc = wrapf(m_e.ph + ((bus.sync && bus.freq_valid) ? m_f : m_inc));
                else
                    m_acc = m_e.ph;
            end else if (bus.sync) begin
                m_acc = 0;
                m_cnt = 0;
            end
            if (bus.freq_valid) begin
                m_inc    = m_f;
                m_loaded = 1'b1;
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sample_count", int'(bus.sample_count), m_cnt);
            if (bus.output_strobe === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("OUT i=%04h q=%04h phase=%0d exp_phase=%0d", bus.out_i, bus.out_q,
                             bus.phase, mon_e.ph);
                    chk("out_i", int'(bus.out_i), mon_e.i);
                    chk("out_q", int'(bus.out_q), mon_e.q);
                    chk("phase", int'(bus.phase), mon_e.ph);
                    chk("latency", en_cnt - mon_e.tag, 1);
                end
            end
        end
    end

    task automatic step(input bit en, input bit st, input bit sy = 1'b0, input bit fv = 1'b0,
                        input int fo = 0, input bit fz = 1'b0, input bit rn = 1'b1);
        @(negedge clk);
        #1;
        bus.enable       = en;
        bus.input_strobe = st;
        bus.sync         = sy;
        bus.freq_valid   = fv;
        bus.freq_offset  = 16'(fo);
        bus.freeze       = fz;
        bus.in_i         = 16'($urandom);
        bus.in_q         = 16'($urandom);
        rst_n            = rn;
    endtask

    initial begin
        bus.enable       = 1'b1;
        bus.input_strobe = 1'b0;
        bus.sync         = 1'b0;
        bus.freq_valid   = 1'b0;
        bus.freq_offset  = '0;
        bus.freeze       = 1'b0;
        bus.in_i         = '0;
        bus.in_q         = '0;

        // Reset with a stray strobe present: nothing may come out of it.
        repeat (3) step(1, 1, 1, 1, 500, 0, 0);
        @(negedge clk);
        chk("rst_out_i", int'(bus.out_i), 0);
        chk("rst_out_q", int'(bus.out_q), 0);
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_strobe", int'(bus.output_strobe), 0);
        chk("rst_count", int'(bus.sample_count), 0);

        // IDLE: no increment loaded, phase stays 0.
        repeat (3) step(1, 1);

        // Ramp through +PI and wrap.
        step(1, 0, 0, 1, 100);
        step(1, 0, 1);
        repeat (18) step(1, 1);

        // Negative increment wrapping below -PI.
        step(1, 0, 0, 1, -1000);
        step(1, 0, 1);
        repeat (3) step(1, 1);

        // Increment saturation in both directions; exactly PI is kept.
        step(1, 0, 0, 1, 5000);
        step(1, 0, 1);
        repeat (3) step(1, 1);
        step(1, 0, 0, 1, -5000);
        step(1, 0, 1);
        repeat (3) step(1, 1);

        // Freeze for three samples mid-ramp.
        step(1, 0, 0, 1, 100);
        step(1, 0, 1);
        repeat (5) step(1, 1);
        repeat (3) step(1, 1, 0, 0, 0, 1);
        repeat (2) step(1, 1);

        // sync + freq_valid together with a sample.
        step(1, 1, 1, 1, 300);
        repeat (3) step(1, 1);

        // freq_valid without sync applies from the following step.
        step(1, 1, 0, 1, -700);
        repeat (3) step(1, 1);

        // sample_count saturation.
        step(1, 0, 1);
        repeat (20) step(1, 1);

        // Randomised traffic with enable stalls.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 30) == 0, $urandom_range(0, 20) == 0,
                 int'($urandom_range(0, 8000)) - 4000, $urandom_range(0, 5) == 0);
        end
        repeat (4) step(1, 0);
        chk("drain_before_reset", sb.size(), 0);

        // Reset straight after sample 7: sample 7 must never appear.
        step(1, 0, 0, 1, 200);
        step(1, 0, 1);
        repeat (7) step(1, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (5) step(1, 0);
        // Back in IDLE: phase 0, count restarting from 0.
        repeat (3) step(1, 1);
        repeat (4) step(1, 0);
        chk("drain_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
